// File: rtl/saes_pkg.sv
// Shared S-AES tables, GF(16) arithmetic and inverse round primitives
// used by the iterative decryptor and its key schedule.
package saes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARK2,
        ST_RND1,
        ST_RND0,
        ST_DONE
    } dec_state_t;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    localparam logic [3:0] SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
        4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
    };

    // Shift-and-add multiply, reducing x^4 back into x+1 on each doubling.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    function automatic logic [7:0] key_g(input logic [7:0] w, input logic [7:0] rcon);
        return {SBOX[w[3:0]], SBOX[w[7:4]]} ^ rcon;
    endfunction

    function automatic logic [15:0] inv_sub16(input logic [15:0] s);
        return {INV_SBOX[s[15:12]], INV_SBOX[s[11:8]], INV_SBOX[s[7:4]], INV_SBOX[s[3:0]]};
    endfunction

    function automatic logic [15:0] inv_shift16(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [7:0] inv_mix_col(input logic [7:0] c);
        return {gf16_mul(4'h9, c[7:4]) ^ gf16_mul(4'h2, c[3:0]),
                gf16_mul(4'h2, c[7:4]) ^ gf16_mul(4'h9, c[3:0])};
    endfunction

    function automatic logic [15:0] inv_mix16(input logic [15:0] s);
        return {inv_mix_col(s[15:8]), inv_mix_col(s[7:0])};
    endfunction

endpackage

// File: rtl/saes_key_sched.sv
// Combinational S-AES key expansion: cipher key -> three round keys.
module saes_key_sched
    import saes_pkg::*;
(
    input  logic [15:0] key_q,
    output logic [15:0] k0,
    output logic [15:0] k1,
    output logic [15:0] k2
);

    logic [7:0] w0, w1, w2, w3, w4, w5;

    assign w0 = key_q[15:8];
    assign w1 = key_q[7:0];
    assign w2 = w0 ^ key_g(w1, RCON1);
    assign w3 = w2 ^ w1;
    assign w4 = w2 ^ key_g(w3, RCON2);
    assign w5 = w4 ^ w3;

    assign k0 = key_q;
    assign k1 = {w2, w3};
    assign k2 = {w4, w5};

endmodule

// File: rtl/saes_dec_iter.sv
// Iterative S-AES decryptor: one inverse round-stage per clock behind
// valid/ready handshakes on both the ciphertext and plaintext sides.
module saes_dec_iter
    import saes_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [15:0] Cipher_Text,
    input  logic [15:0] Key,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [15:0] Plain_Text
);

    dec_state_t  state;
    logic [15:0] st;
    logic [15:0] key_q;
    logic [15:0] k0, k1, k2;
    logic [15:0] rnd1_val;
    logic [15:0] rnd0_val;

    saes_key_sched u_key_sched (
        .key_q (key_q),
        .k0    (k0),
        .k1    (k1),
        .k2    (k2)
    );

    assign rnd1_val = inv_mix16(inv_sub16(inv_shift16(st)) ^ k1);
    assign rnd0_val = inv_sub16(inv_shift16(st)) ^ k0;

    // In_Ready/Out_Valid are registered alongside the state so that
    // In_Ready stays low until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= ST_IDLE;
            st         <= 16'h0000;
            key_q      <= 16'h0000;
            Plain_Text <= 16'h0000;
            In_Ready   <= 1'b0;
            Out_Valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (In_Valid && In_Ready) begin
                        st       <= Cipher_Text;
                        key_q    <= Key;
                        state    <= ST_ARK2;
                        In_Ready <= 1'b0;
                    end else begin
                        In_Ready <= 1'b1;
                    end
                end
                ST_ARK2: begin
                    st    <= st ^ k2;
                    state <= ST_RND1;
                end
                ST_RND1: begin
                    st    <= rnd1_val;
                    state <= ST_RND0;
                end
                ST_RND0: begin
                    st         <= rnd0_val;
                    Plain_Text <= rnd0_val;
                    Out_Valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        In_Ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    Out_Valid <= 1'b0;
                    In_Ready  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saes_dec_iter.sv
// Scoreboard bench for saes_dec_iter using known S-AES vectors.
module tb_saes_dec_iter;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [15:0] Cipher_Text;
    logic [15:0] Key;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [15:0] Plain_Text;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb [$];

    saes_dec_iter dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .Cipher_Text (Cipher_Text),
        .Key         (Key),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Plain_Text  (Plain_Text)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Output-side monitor: every completed output handshake pops one expected word.
    always @(negedge CLK) begin
        if (RST_n && Out_Valid && Out_Ready) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("plain_text", 32'(Plain_Text), 32'(sb.pop_front()));
        end
    end

    task automatic send(input logic [15:0] ct, input logic [15:0] key, input logic [15:0] exp_pt,
                        input logic [15:0] ct_after, input logic [15:0] key_after);
        int n;
        In_Valid    = 1'b1;
        Cipher_Text = ct;
        Key         = key;
        n = 0;
        while (!In_Ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(In_Ready), 32'd1);
        sb.push_back(exp_pt);
        tick();
        In_Valid    = 1'b0;
        Cipher_Text = ct_after;
        Key         = key_after;
        n = 0;
        while (!Out_Valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("pt_at_valid", 32'(Plain_Text), 32'(exp_pt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n       = 1'b0;
        In_Valid    = 1'b0;
        Out_Ready   = 1'b1;
        Cipher_Text = 16'h0000;
        Key         = 16'h0000;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            In_Valid    = 1'($urandom);
            Out_Ready   = 1'($urandom);
            Cipher_Text = 16'($urandom);
            Key         = 16'($urandom);
            tick();
            chk("rst_out_valid", 32'(Out_Valid), 32'd0);
            chk("rst_plain", 32'(Plain_Text), 32'h0000);
            chk("rst_in_ready", 32'(In_Ready), 32'd0);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        RST_n     = 1'b1;
        chk("rel_in_ready_pre", 32'(In_Ready), 32'd0);
        tick();
        chk("rel_in_ready", 32'(In_Ready), 32'd1);
        chk("rel_out_valid", 32'(Out_Valid), 32'd0);

        // Reference vector with round-key checks
        send(16'h24EC, 16'h4AF5, 16'hD728, 16'h1234, 16'h5678);
        chk("k1", 32'(dut.k1), 32'hDD28);
        chk("k2", 32'(dut.k2), 32'h87AF);
        tick();
        chk("idle_in_ready", 32'(In_Ready), 32'd1);
        chk("idle_out_valid", 32'(Out_Valid), 32'd0);

        send(16'h0738, 16'hA73B, 16'h6F6B, 16'h0000, 16'h0000);
        tick();

        // Backpressure with ignored requests
        Out_Ready = 1'b0;
        send(16'h24EC, 16'h4AF5, 16'hD728, 16'h0000, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            In_Valid    = ~In_Valid;
            Cipher_Text = 16'($urandom);
            Key         = 16'($urandom);
            tick();
            chk("bp_out_valid", 32'(Out_Valid), 32'd1);
            chk("bp_plain", 32'(Plain_Text), 32'hD728);
            chk("bp_in_ready", 32'(In_Ready), 32'd0);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        tick();
        chk("bp_sb_drained", 32'(sb.size()), 32'd0);
        chk("bp_after_valid", 32'(Out_Valid), 32'd0);
        chk("bp_after_ready", 32'(In_Ready), 32'd1);
        chk("bp_after_plain", 32'(Plain_Text), 32'hD728);
        tick();
        chk("bp_no_extra", 32'(Out_Valid), 32'd0);

        // Inputs change right after accept
        send(16'h24EC, 16'h4AF5, 16'hD728, 16'hFFFF, 16'h0000);
        tick();

        // Asynchronous reset while in RND1
        In_Valid    = 1'b1;
        Cipher_Text = 16'h0738;
        Key         = 16'hA73B;
        chk("rr_in_ready", 32'(In_Ready), 32'd1);
        tick();
        In_Valid = 1'b0;
        tick();
        #2;
        RST_n = 1'b0;
        #1;
        chk("rr_out_valid", 32'(Out_Valid), 32'd0);
        chk("rr_plain", 32'(Plain_Text), 32'h0000);
        chk("rr_in_ready", 32'(In_Ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_hold_valid", 32'(Out_Valid), 32'd0);
        end
        RST_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_post_valid", 32'(Out_Valid), 32'd0);
        end
        send(16'h0738, 16'hA73B, 16'h6F6B, 16'h0000, 16'h0000);
        tick();

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
